// File: rtl/trit_pkg.sv
// rtl/trit_pkg.sv - trit encodings, FSM state type and trit decode helper
package trit_pkg;

    localparam logic [1:0] TRIT_ZERO = 2'b00;
    localparam logic [1:0] TRIT_POS  = 2'b01;
    localparam logic [1:0] TRIT_NEG  = 2'b11;
    localparam logic [1:0] TRIT_INV  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // The invalid code folds to zero so conversion continues regardless of checking.
    function automatic logic signed [1:0] trit_to_int(input logic [1:0] code);
        case (code)
            TRIT_POS: return 2'sb01;
            TRIT_NEG: return 2'sb11;
            default:  return 2'sb00;
        endcase
    endfunction

endpackage

// File: rtl/trit_decode.sv
// rtl/trit_decode.sv - combinational 2-bit trit code to signed value plus invalid flag
module trit_decode
    import trit_pkg::*;
(
    input  logic [1:0]        code,
    output logic signed [1:0] value,
    output logic              inv
);

    assign value = trit_to_int(code);
    assign inv   = (code == TRIT_INV);

endmodule

// File: rtl/trit27_to_bin.sv
// rtl/trit27_to_bin.sv - serial balanced-ternary word to two's-complement converter
// Optional invalid-trit flag on o_err when TRIT_ERR_CHECK_EN is defined.
module trit27_to_bin
    import trit_pkg::*;
#(
    parameter int NUM_TRITS = 27,
    parameter int OUT_W     = 43
) (
    input  logic                   i_clk,
    input  logic                   i_arst_n,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic [2*NUM_TRITS-1:0] i_trits,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [OUT_W-1:0]       o_value,
    output logic                   o_err
);

    localparam int CNT_W = $clog2(NUM_TRITS);

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q;
    logic [2*NUM_TRITS-1:0] sr_q;
    logic [OUT_W-1:0]       acc_q;
    logic [OUT_W-1:0]       acc_next;
    logic signed [1:0]      trit_val;
    logic                   trit_inv;
    logic                   accept;
    logic                   last;

    // Most significant trit sits at the top of the shift register (Horner order).
    trit_decode u_trit_decode (
        .code  (sr_q[2*NUM_TRITS-1 -: 2]),
        .value (trit_val),
        .inv   (trit_inv)
    );

    assign accept   = i_valid && o_ready;
    assign last     = (state_q == ST_CONV) && (cnt_q == '0);
    assign acc_next = (acc_q << 1) + acc_q + {{(OUT_W-2){trit_val[1]}}, trit_val};

    always_ff @(posedge i_clk) begin
        if (!i_arst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        o_ready = 1'b0;
        o_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                o_ready = i_arst_n;
                if (accept) state_d = ST_CONV;
            end
            ST_CONV: begin
                if (cnt_q == '0) state_d = ST_DONE;
            end
            ST_DONE: begin
                o_valid = 1'b1;
                if (i_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_arst_n) begin
            cnt_q   <= '0;
            sr_q    <= '0;
            acc_q   <= '0;
            o_value <= '0;
        end else if (accept) begin
            cnt_q <= CNT_W'(NUM_TRITS - 1);
            sr_q  <= i_trits;
            acc_q <= '0;
        end else if (state_q == ST_CONV) begin
            cnt_q <= cnt_q - CNT_W'(1);
            sr_q  <= sr_q << 2;
            acc_q <= acc_next;
            if (last) o_value <= acc_next;
        end
    end

`ifdef TRIT_ERR_CHECK_EN
    logic err_q;

    always_ff @(posedge i_clk) begin
        if (!i_arst_n) begin
            err_q <= 1'b0;
            o_err <= 1'b0;
        end else if (accept) begin
            err_q <= 1'b0;
            o_err <= 1'b0;
        end else if (state_q == ST_CONV) begin
            err_q <= err_q | trit_inv;
            if (last) o_err <= err_q | trit_inv;
        end
    end
`else
    logic unused_inv;
    assign unused_inv = trit_inv;
    assign o_err      = 1'b0;
`endif

endmodule
